// File: rtl/egress_cpld_gen_if.sv
// egress_cpld_gen_if: read-request, register-read and egress TLP stream signals of the completion generator
interface egress_cpld_gen_if;
    logic        rdreq_valid;
    logic        rdreq_rdy;
    logic [15:0] rdreq_req_id;
    logic [7:0]  rdreq_tag;
    logic [11:0] rdreq_addr;
    logic [9:0]  rdreq_len;
    logic [2:0]  rdreq_tc;
    logic [1:0]  rdreq_attr;
    logic        rd_req;
    logic [9:0]  rd_tdest;
    logic [31:0] rd_data;
    logic        rd_vld;
    logic [63:0] tx_data;
    logic [1:0]  tx_keep;
    logic        tx_last;
    logic        tx_valid;
    logic        tx_rdy;

    modport master (
        output rdreq_valid, rdreq_req_id, rdreq_tag, rdreq_addr, rdreq_len, rdreq_tc, rdreq_attr,
        input  rdreq_rdy,
        input  rd_req, rd_tdest,
        output rd_data, rd_vld,
        input  tx_data, tx_keep, tx_last, tx_valid,
        output tx_rdy
    );

    modport slave (
        input  rdreq_valid, rdreq_req_id, rdreq_tag, rdreq_addr, rdreq_len, rdreq_tc, rdreq_attr,
        output rdreq_rdy,
        output rd_req, rd_tdest,
        input  rd_data, rd_vld,
        output tx_data, tx_keep, tx_last, tx_valid,
        input  tx_rdy
    );
endinterface

// File: rtl/egress_cpld_gen.sv
// egress_cpld_gen: turns a register-space memory read into one register read and a CplD (1 DW) or a UR Cpl (any other length)
module egress_cpld_gen #(
    parameter int RD_TIMEOUT = 255
) (
    input logic        clk,
    input logic        rst,
    input logic [15:0] completer_id,
    egress_cpld_gen_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, BEAT0, BEAT1} state_t;
    state_t      state;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [6:0]  lower_addr;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic        ur;
    logic [7:0]  cnt;
    logic [31:0] data;
    logic [31:0] dw2;
    logic        accept;

    // Header DWs travel in PCIe byte order: byte 0 (fmt/type) lands in bits [7:0]
    function automatic logic [31:0] be(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [63:0] beat0(input logic [2:0] t, input logic [1:0] a, input logic u);
        return {be({completer_id, 2'b00, u, 1'b0, 12'd4}),
                be({1'b0, u ? 2'b00 : 2'b10, 5'b01010, 1'b0, t, 4'b0, 2'b00, a, 2'b00, u ? 10'd0 : 10'd1})};
    endfunction

    assign dw2    = be({req_id, tag, 1'b0, lower_addr});
    assign accept = bus.rdreq_valid && bus.rdreq_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.rdreq_rdy <= 1'b0;
            bus.rd_req    <= 1'b0;
            bus.rd_tdest  <= '0;
            bus.tx_valid  <= 1'b0;
            bus.tx_last   <= 1'b0;
            bus.tx_keep   <= '0;
            bus.tx_data   <= '0;
            cnt           <= '0;
            ur            <= 1'b0;
            req_id        <= '0;
            tag           <= '0;
            lower_addr    <= '0;
            tc            <= '0;
            attr          <= '0;
            data          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.rdreq_rdy <= !accept;
                    if (accept) begin
                        req_id       <= bus.rdreq_req_id;
                        tag          <= bus.rdreq_tag;
                        lower_addr   <= bus.rdreq_addr[6:0];
                        tc           <= bus.rdreq_tc;
                        attr         <= bus.rdreq_attr;
                        bus.rd_tdest <= bus.rdreq_addr[11:2];
                        if (bus.rdreq_len == 10'd1) begin
                            state      <= RD;
                            bus.rd_req <= 1'b1;
                        end else begin
                            ur           <= 1'b1;
                            state        <= BEAT0;
                            bus.tx_valid <= 1'b1;
                            bus.tx_keep  <= 2'b11;
                            bus.tx_data  <= beat0(bus.rdreq_tc, bus.rdreq_attr, 1'b1);
                        end
                    end
                end
                RD: begin
                    bus.rd_req <= 1'b0;
                    cnt        <= '0;
                    if (bus.rd_vld) begin
                        data         <= bus.rd_data;
                        state        <= BEAT0;
                        bus.tx_valid <= 1'b1;
                        bus.tx_keep  <= 2'b11;
                        bus.tx_data  <= beat0(tc, attr, 1'b0);
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    // A timed-out read still completes successfully, with all-ones data
                    if (bus.rd_vld || cnt == 8'(RD_TIMEOUT - 1)) begin
                        data         <= bus.rd_vld ? bus.rd_data : 32'hFFFF_FFFF;
                        state        <= BEAT0;
                        bus.tx_valid <= 1'b1;
                        bus.tx_keep  <= 2'b11;
                        bus.tx_data  <= beat0(tc, attr, 1'b0);
                    end
                end
                BEAT0: begin
                    if (bus.tx_rdy) begin
                        state       <= BEAT1;
                        bus.tx_data <= {ur ? 32'h0 : data, dw2};
                        bus.tx_keep <= ur ? 2'b01 : 2'b11;
                        bus.tx_last <= 1'b1;
                    end
                end
                BEAT1: begin
                    if (bus.tx_rdy) begin
                        state         <= IDLE;
                        bus.tx_valid  <= 1'b0;
                        bus.tx_last   <= 1'b0;
                        bus.tx_keep   <= '0;
                        bus.tx_data   <= '0;
                        ur            <= 1'b0;
                        bus.rdreq_rdy <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_egress_cpld_gen.sv
// tb_egress_cpld_gen: directed vectors with hand-computed completion beats
module tb_egress_cpld_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cid = 16'h0200;
    int          errors = 0;
    int          checks = 0;
    int          hs_cnt = 0;
    int          rdreq_cnt = 0;
    int          lat;
    int          h0;
    int          r0;
    logic [63:0] d0, d1;
    logic [1:0]  k0, k1;
    logic        l0, l1, stable;

    egress_cpld_gen_if bus ();

    egress_cpld_gen #(.RD_TIMEOUT(8)) dut (
        .clk(clk),
        .rst(rst),
        .completer_id(cid),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.tx_valid && bus.tx_rdy) hs_cnt <= hs_cnt + 1;
        if (bus.rd_req) rdreq_cnt <= rdreq_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input logic [7:0] tg, input logic [15:0] rid, input logic [11:0] ad,
                       input logic [9:0] ln, input logic [2:0] t, input logic [1:0] a);
        for (int k = 0; k < 50 && !bus.rdreq_rdy; k++) @(negedge clk);
        check("rdy_idle", bus.rdreq_rdy, 1);
        bus.rdreq_tag    = tg;
        bus.rdreq_req_id = rid;
        bus.rdreq_addr   = ad;
        bus.rdreq_len    = ln;
        bus.rdreq_tc     = t;
        bus.rdreq_attr   = a;
        bus.rdreq_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rdreq_valid  = 1'b0;
    endtask

    task automatic wait_tx(input int start);
        lat = start;
        while (!bus.tx_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic beats(input int hold);
        d0 = bus.tx_data; k0 = bus.tx_keep; l0 = bus.tx_last; stable = 1'b1;
        repeat (hold) begin
            bus.tx_rdy = 1'b0;
            @(negedge clk);
            if ({bus.tx_valid, bus.tx_data, bus.tx_keep, bus.tx_last, bus.rdreq_rdy} !== {1'b1, d0, k0, l0, 1'b0}) stable = 1'b0;
        end
        bus.tx_rdy = 1'b1;
        @(negedge clk);
        d1 = bus.tx_data; k1 = bus.tx_keep; l1 = bus.tx_last;
        repeat (hold) begin
            bus.tx_rdy = 1'b0;
            @(negedge clk);
            if ({bus.tx_valid, bus.tx_data, bus.tx_keep, bus.tx_last, bus.rdreq_rdy} !== {1'b1, d1, k1, l1, 1'b0}) stable = 1'b0;
        end
        bus.tx_rdy = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.rdreq_valid = 1'b0; bus.rdreq_req_id = '0; bus.rdreq_tag = '0; bus.rdreq_addr = '0;
        bus.rdreq_len = 10'd1; bus.rdreq_tc = '0; bus.rdreq_attr = '0;
        bus.rd_vld = 1'b0; bus.rd_data = '0; bus.tx_rdy = 1'b1;
        #1;
        check("rst_rdy", bus.rdreq_rdy, 0);
        check("rst_tx", {bus.tx_valid, bus.tx_last, bus.tx_keep}, 0);
        check("rst_data", bus.tx_data, 0);
        check("rst_rd", {bus.rd_req, bus.rd_tdest}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", bus.rdreq_rdy, 1);

        req(8'h15, 16'h0100, 12'h0A4, 10'd1, 3'd0, 2'd0);
        check("basic_rd_req", {bus.rd_req, bus.rd_tdest, bus.rdreq_rdy}, {1'b1, 10'h029, 1'b0});
        @(negedge clk);
        check("basic_rd_req_pulse", bus.rd_req, 0);
        bus.rd_vld = 1'b1; bus.rd_data = 32'h1234_5678;
        @(negedge clk);
        bus.rd_vld = 1'b0;
        wait_tx(3);
        check("basic_lat", lat, 3);
        beats(0);
        check("basic_b0", d0, 64'h04000002_0100004A);
        check("basic_b0_kl", {k0, l0}, 3'b110);
        check("basic_b1", d1, 64'h12345678_24150001);
        check("basic_b1_kl", {k1, l1}, 3'b111);
        check("basic_rdy_back", bus.rdreq_rdy, 1);

        r0 = rdreq_cnt;
        req(8'h22, 16'h0101, 12'h010, 10'd2, 3'b101, 2'b10);
        wait_tx(1);
        check("ur_lat", lat, 1);
        beats(0);
        check("ur_b0", d0, 64'h04200002_0020500A);
        check("ur_b1", d1, 64'h00000000_10220101);
        check("ur_b1_kl", {k1, l1}, 3'b011);
        check("ur_no_rd_req", rdreq_cnt - r0, 0);

        req(8'h33, 16'h0100, 12'h000, 10'd1, 3'd0, 2'd0);
        wait_tx(1);
        check("to_lat", lat, 10);
        beats(0);
        check("to_b0", d0, 64'h04000002_0100004A);
        check("to_b1", d1, 64'hFFFFFFFF_00330001);

        bus.rd_vld = 1'b1; bus.rd_data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.rd_vld = 1'b0;
        check("stray_ignored", {bus.tx_valid, bus.rd_req}, 0);
        req(8'h78, 16'h0100, 12'h004, 10'd1, 3'd0, 2'd0);
        bus.rd_vld = 1'b1; bus.rd_data = 32'h0BAD_CAFE;
        @(negedge clk);
        bus.rd_vld = 1'b0;
        wait_tx(2);
        check("stray_lat", lat, 2);
        beats(0);
        check("stray_b1", d1, 64'h0BADCAFE_04780001);

        h0 = hs_cnt;
        req(8'h44, 16'h0100, 12'h0FC, 10'd1, 3'd0, 2'd0);
        check("bp_tdest", bus.rd_tdest, 10'h03F);
        bus.rd_vld = 1'b1; bus.rd_data = 32'hCAFE_F00D;
        @(negedge clk);
        bus.rd_vld = 1'b0;
        wait_tx(2);
        check("bp_lat", lat, 2);
        beats(5);
        check("bp_stable", stable, 1);
        check("bp_hs", hs_cnt - h0, 2);
        check("bp_b0", d0, 64'h04000002_0100004A);
        check("bp_b1", d1, 64'hCAFEF00D_7C440001);

        req(8'h55, 16'h0100, 12'h0A4, 10'd1, 3'd0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_wait", {bus.tx_valid, bus.rd_req, bus.rdreq_rdy}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst2", bus.rdreq_rdy, 1);

        req(8'h5A, 16'h0100, 12'h0A4, 10'd1, 3'd0, 2'd0);
        bus.rd_vld = 1'b1; bus.rd_data = 32'h1111_2222;
        @(negedge clk);
        bus.rd_vld = 1'b0; bus.tx_rdy = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_beat0_v", {bus.tx_valid, bus.tx_keep, bus.tx_last}, 0);
        check("rst_beat0_d", bus.tx_data, 0);
        bus.tx_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        req(8'h66, 16'h0100, 12'h008, 10'd1, 3'd0, 2'd0);
        @(negedge clk);
        bus.rd_vld = 1'b1; bus.rd_data = 32'hA5A5_5A5A;
        @(negedge clk);
        bus.rd_vld = 1'b0;
        wait_tx(3);
        check("post_rst_lat", lat, 3);
        beats(0);
        check("post_rst_b0", d0, 64'h04000002_0100004A);
        check("post_rst_b1", d1, 64'hA5A55A5A_08660001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
